dma_cfg_sequencer: RTL

//  Upstream command source for the AXI-Lite master; this block is its sole driver (one-cycle wren/rden pulses).
//  On start, programs the DMA engine registers (SRC, DST, LEN, CTRL.go) via the master, then polls STATUS until done/error.

---
 rtl/dma_cfg_pkg.sv | 22 ++
 rtl/dma_cfg_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/dma_cfg_pkg.sv
// dma_cfg_pkg: DMA register map, bit constants, FSM state and error code types for dma_cfg_sequencer
package dma_cfg_pkg;
  localparam logic [31:0] OFF_CTRL   = 32'h00;
  localparam logic [31:0] OFF_SRC    = 32'h04;
  localparam logic [31:0] OFF_DST    = 32'h08;
  localparam logic [31:0] OFF_LEN    = 32'h0C;
  localparam logic [31:0] OFF_STATUS = 32'h10;
  localparam logic [31:0] CTRL_GO    = 32'h1;
  localparam logic [31:0] STATUS_W1C = 32'h3;
  localparam int STATUS_DONE = 0;
  localparam int STATUS_ERR  = 1;
  typedef enum logic [3:0] {
    S_IDLE, S_WR_ISSUE, S_WR_WAIT, S_POLL_WAIT, S_RD_ISSUE,
    S_RD_WAIT, S_CLR_ISSUE, S_CLR_WAIT, S_FIN
  } state_t;
  typedef enum logic [1:0] {
    ERR_OK = 2'b00, ERR_RSP = 2'b01, ERR_POLL = 2'b10, ERR_LEN = 2'b11
  } err_t;
  function automatic logic [31:0] wr_off(input logic [1:0] i);
    return i == 2'd0 ? OFF_SRC : i == 2'd1 ? OFF_DST : i == 2'd2 ? OFF_LEN : OFF_CTRL;
  endfunction
endpackage

// File: rtl/dma_cfg_sequencer.sv
// dma_cfg_sequencer: programs SRC/DST/LEN/CTRL.go over the register master, polls STATUS, clears it and reports done/err_code
module dma_cfg_sequencer
  import dma_cfg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int unsigned POLL_GAP    = 16,
  parameter int unsigned MAX_POLLS   = 1024,
  parameter int unsigned RSP_TIMEOUT = 256
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [31:0] len,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err_code,
  output logic [31:0] status_last,
  output logic        wren,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_done,
  output logic        rden,
  output logic [31:0] rd_addr,
  input  logic [31:0] rd_data,
  input  logic        rd_done
);
  state_t      state;
  logic [1:0]  wr_idx;
  logic [31:0] dst_q, len_q, gap_cnt, rsp_cnt, poll_cnt;
  logic        rsp_to;
  assign rsp_to = rsp_cnt == RSP_TIMEOUT - 1;
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_code    <= 2'b00;
      status_last <= 32'h0;
      wren        <= 1'b0;
      wr_addr     <= 32'h0;
      wr_data     <= 32'h0;
      rden        <= 1'b0;
      rd_addr     <= 32'h0;
      wr_idx      <= 2'd0;
      dst_q       <= 32'h0;
      len_q       <= 32'h0;
      gap_cnt     <= 32'h0;
      rsp_cnt     <= 32'h0;
      poll_cnt    <= 32'h0;
    end else begin
      wren <= 1'b0;
      rden <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          dst_q    <= dst_addr;
          len_q    <= len;
          busy     <= 1'b1;
          wr_idx   <= 2'd0;
          poll_cnt <= 32'h0;
          if (len == 32'h0) begin
            err_code <= ERR_LEN;
            done     <= 1'b1;
            state    <= S_FIN;
          end else begin
            err_code <= ERR_OK;
            wren     <= 1'b1;
            wr_addr  <= BASE_ADDR + wr_off(2'd0);
            wr_data  <= src_addr;
            state    <= S_WR_ISSUE;
          end
        end
        S_WR_ISSUE: begin
          rsp_cnt <= 32'h0;
          state   <= S_WR_WAIT;
        end
        S_WR_WAIT:
          if (wr_done) begin
            if (wr_idx == 2'd3) begin
              gap_cnt <= 32'h0;
              state   <= S_POLL_WAIT;
            end else begin
              wr_idx  <= wr_idx + 2'd1;
              wren    <= 1'b1;
              wr_addr <= BASE_ADDR + wr_off(wr_idx + 2'd1);
              wr_data <= wr_idx == 2'd0 ? dst_q : wr_idx == 2'd1 ? len_q : CTRL_GO;
              state   <= S_WR_ISSUE;
            end
          end else if (rsp_to) begin
            err_code <= ERR_RSP;
            done     <= 1'b1;
            state    <= S_FIN;
          end else
            rsp_cnt <= rsp_cnt + 32'd1;
        S_POLL_WAIT:
          if (gap_cnt == POLL_GAP - 1) begin
            rden    <= 1'b1;
            rd_addr <= BASE_ADDR + OFF_STATUS;
            state   <= S_RD_ISSUE;
          end else
            gap_cnt <= gap_cnt + 32'd1;
        S_RD_ISSUE: begin
          rsp_cnt <= 32'h0;
          state   <= S_RD_WAIT;
        end
        S_RD_WAIT:
          if (rd_done) begin
            status_last <= rd_data;
            poll_cnt    <= poll_cnt + 32'd1;
            if (rd_data[STATUS_ERR] || rd_data[STATUS_DONE]) begin
              err_code <= rd_data[STATUS_ERR] ? ERR_POLL : ERR_OK;
              wren     <= 1'b1;
              wr_addr  <= BASE_ADDR + OFF_STATUS;
              wr_data  <= STATUS_W1C;
              state    <= S_CLR_ISSUE;
            end else if (poll_cnt + 32'd1 == MAX_POLLS) begin
              err_code <= ERR_POLL;
              done     <= 1'b1;
              state    <= S_FIN;
            end else begin
              gap_cnt <= 32'h0;
              state   <= S_POLL_WAIT;
            end
          end else if (rsp_to) begin
            err_code <= ERR_RSP;
            done     <= 1'b1;
            state    <= S_FIN;
          end else
            rsp_cnt <= rsp_cnt + 32'd1;
        S_CLR_ISSUE: begin
          rsp_cnt <= 32'h0;
          state   <= S_CLR_WAIT;
        end
        S_CLR_WAIT:
          if (wr_done) begin
            done  <= 1'b1;
            state <= S_FIN;
          end else if (rsp_to) begin
            err_code <= ERR_RSP;
            done     <= 1'b1;
            state    <= S_FIN;
          end else
            rsp_cnt <= rsp_cnt + 32'd1;
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule
